// File: rtl/hexled_scan_if.sv
// Load handshake and per-digit decoder drive bundle for hexled_scan.
interface hexled_scan_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4*DIGITS
);
  logic              load_valid;
  logic              load_ready;
  logic [WIDTH-1:0]  load_value;
  logic              load_signed;
  logic              lz_blank_en;
  logic [3:0]        digit_value;
  logic              digit_blank;
  logic              digit_minus;
  logic [DIGITS-1:0] digit_sel;

  modport master (
    output load_valid, load_value, load_signed, lz_blank_en,
    input  load_ready, digit_value, digit_blank, digit_minus, digit_sel
  );
  modport slave (
    input  load_valid, load_value, load_signed, lz_blank_en,
    output load_ready, digit_value, digit_blank, digit_minus, digit_sel
  );
endinterface

// File: rtl/hexled_scan.sv
// Multiplexed multi-digit display front end with leading-zero blanking.
// HEXLED_SCAN_DECIMAL_EN selects binary-to-decimal (double-dabble) display.
module hexled_scan #(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 16,
  parameter int SCAN_DIV = 1024
) (
  input logic          i_clock,
  input logic          i_rst_n,
  hexled_scan_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic                    w_presc_tc;
  logic [DIGITS-1:0][3:0]  r_nib, w_nib_nxt;
  logic                    r_lz, w_lz_nxt;
  logic [DIGITS-1:0]       w_mmask_nxt, w_blank_nxt;
  logic [DIGITS-1:0]       r_sel;
  logic [3:0]              r_val;
  logic                    r_blank, r_minus;

  assign w_presc_tc = (r_presc == PW'(SCAN_DIV-1));
  assign w_idx_nxt  = !w_presc_tc ? r_idx :
                      (r_idx == IW'(DIGITS-1)) ? '0 : r_idx + IW'(1);

`ifdef HEXLED_SCAN_DECIMAL_EN
  localparam int BD = DIGITS + DIGITS/4 + 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_CONV} state_t;
  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_bin, w_mag;
  logic [WIDTH:0]      w_neg_ext;
  logic [4*BD-1:0]     r_bcd, w_bcd_adj, w_bcd_step;
  logic [CW-1:0]       r_cnt;
  logic                r_neg, r_lz_pend, w_accept, w_last, w_ovf;
  logic [DIGITS-1:0]   r_mmask, w_res_mask;
  int                  w_msd;

  assign w_accept        = bus.load_valid && (r_state == S_IDLE);
  assign w_last          = (r_state == S_CONV) && (r_cnt == CW'(WIDTH-1));
  assign bus.load_ready  = (r_state == S_IDLE);
  assign w_neg_ext       = ~{bus.load_value[WIDTH-1], bus.load_value} + (WIDTH+1)'(1);
  assign w_mag           = (bus.load_signed && bus.load_value[WIDTH-1]) ?
                           w_neg_ext[WIDTH-1:0] : bus.load_value;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CONV;
      S_CONV:  if (w_last)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction precedes the shift; the last step feeds the display directly.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < BD; d++)
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    w_bcd_step = {w_bcd_adj[4*BD-2:0], r_bin[WIDTH-1]};
  end

  always_comb begin
    w_ovf = r_neg && (w_bcd_step[4*(DIGITS-1) +: 4] != 4'd0);
    for (int i = DIGITS; i < BD; i++)
      if (w_bcd_step[4*i +: 4] != 4'd0) w_ovf = 1'b1;
    w_msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (w_bcd_step[4*i +: 4] != 4'd0) w_msd = i;
    w_res_mask = '0;
    for (int i = 0; i < DIGITS; i++)
      w_res_mask[i] = r_neg && (i == w_msd + 1);
    w_nib_nxt   = r_nib;
    w_lz_nxt    = r_lz;
    w_mmask_nxt = r_mmask;
    if (w_last) begin
      w_nib_nxt   = w_ovf ? '0 : w_bcd_step[4*DIGITS-1:0];
      w_mmask_nxt = w_ovf ? '1 : w_res_mask;
      w_lz_nxt    = r_lz_pend;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_lz_pend <= 1'b0;
      r_mmask   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mmask <= w_mmask_nxt;
      if (w_accept) begin
        r_bin     <= w_mag;
        r_bcd     <= '0;
        r_cnt     <= '0;
        r_neg     <= bus.load_signed && bus.load_value[WIDTH-1];
        r_lz_pend <= bus.lz_blank_en;
      end else if (r_state == S_CONV) begin
        r_bin <= r_bin << 1;
        r_bcd <= w_bcd_step;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
`else
  logic w_unused_signed;
  assign w_unused_signed = bus.load_signed;
  assign bus.load_ready  = 1'b1;
  assign w_nib_nxt       = bus.load_valid ? bus.load_value : r_nib;
  assign w_lz_nxt        = bus.load_valid ? bus.lz_blank_en : r_lz;
  assign w_mmask_nxt     = '0;
`endif

  // Blanking is evaluated on next-state values so outputs move with the display.
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    if (i == 0) begin : g_lsd
      assign w_blank_nxt[i] = 1'b0;
    end else begin : g_upper
      assign w_blank_nxt[i] = w_lz_nxt && (w_nib_nxt[DIGITS-1:i] == '0) && !w_mmask_nxt[i];
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_nib   <= '0;
      r_lz    <= 1'b0;
      r_sel   <= DIGITS'(1);
      r_val   <= 4'd0;
      r_blank <= 1'b0;
      r_minus <= 1'b0;
    end else begin
      r_presc <= w_presc_tc ? '0 : r_presc + PW'(1);
      r_idx   <= w_idx_nxt;
      r_nib   <= w_nib_nxt;
      r_lz    <= w_lz_nxt;
      r_sel   <= DIGITS'(1) << w_idx_nxt;
      r_blank <= w_blank_nxt[w_idx_nxt];
      r_minus <= w_mmask_nxt[w_idx_nxt] & ~w_blank_nxt[w_idx_nxt];
      r_val   <= w_blank_nxt[w_idx_nxt] ? 4'd0 : w_nib_nxt[w_idx_nxt];
    end
  end

  assign bus.digit_sel   = r_sel;
  assign bus.digit_value = r_val;
  assign bus.digit_blank = r_blank;
  assign bus.digit_minus = r_minus;
endmodule

// File: tb/tb_hexled_scan.sv
// Directed self-checking bench for hexled_scan (DIGITS=4, SCAN_DIV=4).
module tb_hexled_scan;
  localparam int DIGITS = 4, WIDTH = 16, SCAN_DIV = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  hexled_scan_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus();
  hexled_scan #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .i_clock(clk), .i_rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0, n_fail = 0;
  logic [3:0] cv [DIGITS];
  logic       cb [DIGITS], cm [DIGITS];
  logic       ready_low_seen;

  // Record what each digit shows over one full scan rotation.
  task automatic capture();
    logic [DIGITS-1:0] one = 1;
    for (int d = 0; d < DIGITS; d++) begin cv[d] = 'x; cb[d] = 1'bx; cm[d] = 1'bx; end
    ready_low_seen = 1'b0;
    for (int c = 0; c < DIGITS*SCAN_DIV; c++) begin
      for (int d = 0; d < DIGITS; d++)
        if (bus.digit_sel === (one << d)) begin
          cv[d] = bus.digit_value; cb[d] = bus.digit_blank; cm[d] = bus.digit_minus;
        end
      if (bus.load_ready !== 1'b1) ready_low_seen = 1'b1;
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with inputs scrambled.
  task automatic load(input logic [WIDTH-1:0] v, input logic s, input logic lz);
    bus.load_valid = 1'b1; bus.load_value = v; bus.load_signed = s; bus.lz_blank_en = lz;
    @(posedge clk); #1;
    bus.load_valid = 1'b0; bus.load_value = ~v; bus.load_signed = ~s; bus.lz_blank_en = ~lz;
    @(negedge clk);
  endtask

  function automatic int cur_idx();
    cur_idx = 0;
    for (int d = 0; d < DIGITS; d++) if (bus.digit_sel[d]) cur_idx = d;
  endfunction

  task automatic test_reset();
    logic [DIGITS-1:0] es;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.load_ready, bus.digit_sel, bus.digit_value, bus.digit_blank, bus.digit_minus} !== {1'b1, 4'b0001, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b sel=%b val=%h blank=%b minus=%b, want 1 0001 0 0 0",
               bus.load_ready, bus.digit_sel, bus.digit_value, bus.digit_blank, bus.digit_minus);
    end
    rst_n = 1'b1;
    for (int c = 0; c < DIGITS*SCAN_DIV; c++) begin
      es = 4'b0001 << (c / SCAN_DIV);
      n_checks++;
      if ({bus.digit_sel, bus.digit_value, bus.digit_blank, bus.digit_minus} !== {es, 4'h0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_scan c=%0d: got sel=%b val=%h blank=%b minus=%b, want sel=%b val=0 blank=0 minus=0",
                 c, bus.digit_sel, bus.digit_value, bus.digit_blank, bus.digit_minus, es);
      end
      @(negedge clk);
    end
  endtask

`ifndef HEXLED_SCAN_DECIMAL_EN
  task automatic test_hex();
    logic [3:0] ev [DIGITS] = '{4'hC, 4'h5, 4'h0, 4'hA};
    int i;
    n_checks++;
    if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL hex_ready_before: got %b want 1", bus.load_ready); end
    load(16'hA05C, 1'b0, 1'b0);
    i = cur_idx();
    n_checks++;
    if (bus.digit_value !== ev[i]) begin
      n_fail++; $display("FAIL hex_next_cycle digit%0d: got %h want %h", i, bus.digit_value, ev[i]);
    end
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {ev[d], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hex_a05c digit%0d: got val=%h blank=%b minus=%b, want val=%h blank=0 minus=0", d, cv[d], cb[d], cm[d], ev[d]);
      end
    end
    n_checks++;
    if (ready_low_seen !== 1'b0) begin n_fail++; $display("FAIL hex_ready_drop: got ready low, want always 1"); end
  endtask

  task automatic test_lz();
    logic [3:0] ev [DIGITS] = '{4'hF, 4'h0, 4'h0, 4'h0};
    logic       eb [DIGITS] = '{1'b0, 1'b1, 1'b1, 1'b1};
    load(16'h000F, 1'b0, 1'b1);
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {ev[d], eb[d], 1'b0}) begin
        n_fail++;
        $display("FAIL lz_000f digit%0d: got val=%h blank=%b minus=%b, want val=%h blank=%b minus=0", d, cv[d], cb[d], cm[d], ev[d], eb[d]);
      end
    end
    load(16'h0000, 1'b0, 1'b1);
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {4'h0, eb[d], 1'b0}) begin
        n_fail++;
        $display("FAIL lz_0000 digit%0d: got val=%h blank=%b minus=%b, want val=0 blank=%b minus=0", d, cv[d], cb[d], cm[d], eb[d]);
      end
    end
  endtask
`else
  task automatic test_dec_convert();
    logic [3:0] ev [DIGITS] = '{4'h4, 4'h3, 4'h2, 4'h1};
    int lo;
    load(16'd1234, 1'b0, 1'b0);
    n_checks++;
    if ({bus.digit_value, bus.digit_blank, bus.digit_minus} !== {4'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL dec_old_value: got val=%h blank=%b minus=%b, want 0 0 0", bus.digit_value, bus.digit_blank, bus.digit_minus);
    end
    lo = 0;
    while (bus.load_ready !== 1'b1 && lo < 100) begin lo++; @(negedge clk); end
    n_checks++;
    if (lo != WIDTH) begin n_fail++; $display("FAIL dec_busy_cycles: got %0d want %0d", lo, WIDTH); end
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {ev[d], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL dec_1234 digit%0d: got val=%h blank=%b minus=%b, want val=%h blank=0 minus=0", d, cv[d], cb[d], cm[d], ev[d]);
      end
    end
  endtask

  task automatic test_dec_overflow();
    logic [WIDTH-1:0] vals [2] = '{16'd12345, 16'hFC18};
    logic             sgn  [2] = '{1'b0, 1'b1};
    int lo;
    for (int t = 0; t < 2; t++) begin
      load(vals[t], sgn[t], 1'b0);
      lo = 0;
      while (bus.load_ready !== 1'b1 && lo < 100) begin lo++; @(negedge clk); end
      capture();
      for (int d = 0; d < DIGITS; d++) begin
        n_checks++;
        if ({cb[d], cm[d]} !== {1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL dec_ovf %h digit%0d: got blank=%b minus=%b, want blank=0 minus=1", vals[t], d, cb[d], cm[d]);
        end
      end
    end
  endtask

  task automatic test_dec_signed();
    logic [3:0] ev [DIGITS] = '{4'h7, 4'h0, 4'h0, 4'h0};
    logic       eb [DIGITS] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       em [DIGITS] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] fv [DIGITS] = '{4'h9, 4'h9, 4'h9, 4'h0};
    logic       fm [DIGITS] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lo;
    load(16'hFFF9, 1'b1, 1'b1);
    lo = 0;
    while (bus.load_ready !== 1'b1 && lo < 100) begin lo++; @(negedge clk); end
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {ev[d], eb[d], em[d]}) begin
        n_fail++;
        $display("FAIL dec_neg7 digit%0d: got val=%h blank=%b minus=%b, want val=%h blank=%b minus=%b", d, cv[d], cb[d], cm[d], ev[d], eb[d], em[d]);
      end
    end
    load(16'hFC19, 1'b1, 1'b0);
    lo = 0;
    while (bus.load_ready !== 1'b1 && lo < 100) begin lo++; @(negedge clk); end
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {fv[d], 1'b0, fm[d]}) begin
        n_fail++;
        $display("FAIL dec_neg999 digit%0d: got val=%h blank=%b minus=%b, want val=%h blank=0 minus=%b", d, cv[d], cb[d], cm[d], fv[d], fm[d]);
      end
    end
  endtask

  task automatic test_dec_reset_mid_conv();
    load(16'd1234, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL dec_rst_ready: got %b want 1", bus.load_ready); end
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {4'h0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL dec_rst_display digit%0d: got val=%h blank=%b minus=%b, want 0 0 0", d, cv[d], cb[d], cm[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ev [DIGITS] = '{4'h9, 4'h9, 4'h0, 4'h0};
    int lo;
    bus.load_valid = 1'b1; bus.load_value = 16'd99; bus.load_signed = 1'b0; bus.lz_blank_en = 1'b0;
    @(posedge clk); #1;
    bus.load_value = 16'd77;
    @(negedge clk);
    lo = 0;
    while (bus.load_ready !== 1'b1 && lo < 100) begin lo++; @(negedge clk); end
    bus.load_valid = 1'b0;
    n_checks++;
    if (lo != WIDTH) begin n_fail++; $display("FAIL held_valid_busy: got %0d want %0d", lo, WIDTH); end
    capture();
    for (int d = 0; d < DIGITS; d++) begin
      n_checks++;
      if ({cv[d], cb[d], cm[d]} !== {ev[d], 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL held_valid digit%0d: got val=%h blank=%b minus=%b, want val=%h blank=0 minus=0", d, cv[d], cb[d], cm[d], ev[d]);
      end
    end
  endtask
`endif

  initial begin
    bus.load_valid = 1'b0; bus.load_value = '0; bus.load_signed = 1'b0; bus.lz_blank_en = 1'b0;
    test_reset();
`ifndef HEXLED_SCAN_DECIMAL_EN
    test_hex();
    test_lz();
`else
    test_dec_convert();
    test_dec_overflow();
    test_dec_signed();
    test_dec_reset_mid_conv();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
